// File: rtl/alu_ctrl_seq_if.sv
// ============================================================================
// Module  : alu_ctrl_seq_if
// Brief   : Instruction handshake and datapath control bundle for alu_ctrl_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_ctrl_seq_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [NREG-1:0]   reg_enable;
    logic [3:0]        sel_a;
    logic [3:0]        sel_b;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
    logic [3:0]        opcode;
    logic              busy;
    logic              done;
    logic [15:0]       instr_count;

    modport master (
        output instr, instr_valid,
        input  instr_ready, reg_enable, sel_a, sel_b, imm_sel, imm,
               opcode, busy, done, instr_count
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, reg_enable, sel_a, sel_b, imm_sel, imm,
               opcode, busy, done, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
// ============================================================================
// Module  : alu_ctrl_seq
// Brief   : Four-state control sequencer decoding 16-bit instructions into ALU
//           datapath selects, immediate, opcode and register write enables.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_seq #(
    parameter int         DATA_W = 16,
    parameter int         NREG   = 16,
    parameter logic [3:0] CMP_OP = 4'hB
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_ctrl_seq_if.slave      bus
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_DECODE    = 2'd1;
    localparam logic [1:0] c_EXECUTE   = 2'd2;
    localparam logic [1:0] c_WRITEBACK = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_sel_a;
    logic [3:0]        r_sel_b;
    logic              r_imm_sel;
    logic [DATA_W-1:0] r_imm;
    logic [3:0]        r_opcode;
    logic [NREG-1:0]   r_reg_enable;
    logic              r_done;
    logic [15:0]       r_instr_count;

    logic [3:0]        w_op;
    logic [3:0]        w_ext;
    logic [7:0]        w_imm8;
    logic [NREG-1:0]   w_onehot;
    logic              w_accept;

    assign w_op     = bus.instr[15:12];
    assign w_ext    = bus.instr[7:4];
    assign w_imm8   = bus.instr[7:0];
    assign w_onehot = {{(NREG-1){1'b0}}, 1'b1} << r_sel_a;

    // Ready is masked during reset so nothing looks accepted while the
    // sequencer is being cleared.
    assign bus.instr_ready = (r_state == c_IDLE) && reset;
    assign w_accept        = bus.instr_ready && bus.instr_valid;

    // Fields are decoded straight into the output registers on the accept
    // edge, so the selects are stable for the whole DECODE..WRITEBACK window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_sel_a       <= 4'd0;
            r_sel_b       <= 4'd0;
            r_imm_sel     <= 1'b0;
            r_imm         <= '0;
            r_opcode      <= 4'd0;
            r_reg_enable  <= '0;
            r_done        <= 1'b0;
            r_instr_count <= 16'd0;
        end else begin
            r_reg_enable <= '0;
            r_done       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_sel_a <= bus.instr[11:8];
                        r_sel_b <= bus.instr[3:0];
                        r_imm   <= {{(DATA_W-8){w_imm8[7]}}, w_imm8};
                        if (w_op == 4'd0) begin
                            r_opcode  <= w_ext;
                            r_imm_sel <= 1'b0;
                        end else begin
                            r_opcode  <= w_op;
                            r_imm_sel <= 1'b1;
                        end
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    r_state <= c_EXECUTE;
                end
                c_EXECUTE: begin
                    r_reg_enable <= (r_opcode == CMP_OP) ? '0 : w_onehot;
                    r_done       <= 1'b1;
                    r_state      <= c_WRITEBACK;
                end
                c_WRITEBACK: begin
                    r_instr_count <= r_instr_count + 16'd1;
                    r_state       <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_a       = r_sel_a;
    assign bus.sel_b       = r_sel_b;
    assign bus.imm_sel     = r_imm_sel;
    assign bus.imm         = r_imm;
    assign bus.opcode      = r_opcode;
    assign bus.reg_enable  = r_reg_enable;
    assign bus.done        = r_done;
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.instr_count = r_instr_count;

endmodule

`default_nettype wire
